// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target receiver: FSM encoding, bus-level constants
// and the saturating bit-counter helper.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ACK_ADDR = 3'd2,
    ST_DATA     = 3'd3,
    ST_ACK_DATA = 3'd4,
    ST_IGNORE   = 3'd5
  } i2c_state_e;

  localparam logic       I2C_ACK  = 1'b0;
  localparam logic       I2C_NACK = 1'b1;
  localparam logic       RW_WRITE = 1'b0;
  localparam logic [3:0] BIT_LAST = 4'd7;
  localparam logic [3:0] BIT_SAT  = 4'd8;

  // The counter parks at 8 so a stray extra SCL pulse can never wrap it back to 0.
  function automatic logic [3:0] bit_cnt_inc(input logic [3:0] cnt);
    logic [3:0] nxt;
    if (cnt >= BIT_SAT) begin
      nxt = BIT_SAT;
    end else begin
      nxt = cnt + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/i2c_target_rx_if.sv
// Pin-side and byte-sink signals of the I2C target receiver.
interface i2c_target_rx_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       addr_hit;
  logic       stop_det;
  logic       busy;

  modport slave (
    input  scl_i, sda_i,
    output sda_oe, rx_data, rx_valid, rx_first, addr_hit, stop_det, busy
  );

  modport master (
    output scl_i, sda_i,
    input  sda_oe, rx_data, rx_valid, rx_first, addr_hit, stop_det, busy
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Synchronises one asynchronous I2C line and emits registered rise/fall pulses
// aligned with the delayed level.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  // Synchroniser chain plus edge detect; idle bus level is high, so reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= {SYNC_STAGES{1'b1}};
      r_level <= 1'b1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_level <= r_sync[SYNC_STAGES-1];
      r_rise  <= r_sync[SYNC_STAGES-1] & ~r_level;
      r_fall  <= ~r_sync[SYNC_STAGES-1] & r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target_rx.sv
// I2C target receiver: START/STOP detection, 7-bit address match, ACK generation and
// delivery of written bytes; read requests are left unacknowledged.
module i2c_target_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  i2c_target_rx_if.slave bus
);

  logic       w_scl, w_scl_rise, w_scl_fall;
  logic       w_sda, w_sda_rise, w_sda_fall;
  logic       w_start, w_stop, w_last_bit, w_addr_ok;
  logic [7:0] w_byte;

  i2c_state_e r_state, w_state_nxt;
  logic [6:0] r_shift, w_shift_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_first_flag, w_first_nxt;
  logic       r_sda_oe, w_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic [7:0] r_rx_data, w_data_nxt;
  logic       r_rx_valid, w_valid_nxt;
  logic       r_rx_first, w_rxfirst_nxt;
  logic       r_addr_hit, w_hit_nxt;
  logic       r_stop_det, w_stopdet_nxt;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .i_pin(bus.scl_i),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .i_pin(bus.sda_i),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start    = w_sda_fall & w_scl;
  assign w_stop     = w_sda_rise & w_scl;
  assign w_byte     = {r_shift, w_sda};
  assign w_last_bit = w_scl_rise && (r_cnt == BIT_LAST);
  assign w_addr_ok  = (w_byte[7:1] == DEV_ADDR) && (w_byte[0] == RW_WRITE);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; bus conditions override any coincident SCL edge.
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR: begin
          if (w_last_bit) begin
            w_state_nxt = w_addr_ok ? ST_ACK_ADDR : ST_IGNORE;
          end else begin
            w_state_nxt = ST_ADDR;
          end
        end
        ST_ACK_ADDR, ST_ACK_DATA: begin
          // sda_oe doubles as the "ACK already driven" sub-phase marker.
          if (w_scl_fall && r_sda_oe) begin
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = r_state;
          end
        end
        ST_DATA: begin
          if (w_last_bit) begin
            w_state_nxt = ST_ACK_DATA;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Next values for the datapath and the registered outputs.
  always_comb begin
    w_oe_nxt      = r_sda_oe;
    w_busy_nxt    = r_busy;
    w_cnt_nxt     = r_cnt;
    w_shift_nxt   = r_shift;
    w_first_nxt   = r_first_flag;
    w_data_nxt    = r_rx_data;
    w_valid_nxt   = 1'b0;
    w_rxfirst_nxt = 1'b0;
    w_hit_nxt     = 1'b0;
    w_stopdet_nxt = 1'b0;
    if (w_start || w_stop) begin
      w_oe_nxt      = 1'b0;
      w_busy_nxt    = 1'b0;
      w_cnt_nxt     = 4'd0;
      w_stopdet_nxt = w_stop & ~w_start;
    end else begin
      case (r_state)
        ST_ADDR, ST_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte[6:0];
            w_cnt_nxt   = bit_cnt_inc(r_cnt);
          end else begin
            w_shift_nxt = r_shift;
          end
          if (w_last_bit && (r_state == ST_ADDR)) begin
            w_hit_nxt  = w_addr_ok;
            w_busy_nxt = w_addr_ok;
          end else if (w_last_bit) begin
            w_data_nxt    = w_byte;
            w_valid_nxt   = 1'b1;
            w_rxfirst_nxt = r_first_flag;
            w_first_nxt   = 1'b0;
          end else begin
            w_hit_nxt = 1'b0;
          end
        end
        ST_ACK_ADDR, ST_ACK_DATA: begin
          if (w_scl_fall && !r_sda_oe) begin
            w_oe_nxt = 1'b1;
          end else if (w_scl_fall) begin
            w_oe_nxt    = 1'b0;
            w_cnt_nxt   = 4'd0;
            w_first_nxt = (r_state == ST_ACK_ADDR) ? 1'b1 : r_first_flag;
          end else begin
            w_oe_nxt = r_sda_oe;
          end
        end
        default: w_oe_nxt = 1'b0;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift      <= 7'd0;
      r_cnt        <= 4'd0;
      r_first_flag <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_busy       <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_rx_first   <= 1'b0;
      r_addr_hit   <= 1'b0;
      r_stop_det   <= 1'b0;
    end else begin
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_first_flag <= w_first_nxt;
      r_sda_oe     <= w_oe_nxt;
      r_busy       <= w_busy_nxt;
      r_rx_data    <= w_data_nxt;
      r_rx_valid   <= w_valid_nxt;
      r_rx_first   <= w_rxfirst_nxt;
      r_addr_hit   <= w_hit_nxt;
      r_stop_det   <= w_stopdet_nxt;
    end
  end

  assign bus.sda_oe   = r_sda_oe;
  assign bus.busy     = r_busy;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_first = r_rx_first;
  assign bus.addr_hit = r_addr_hit;
  assign bus.stop_det = r_stop_det;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Drives I2C write/read transactions through an open-drain bus model and checks the
// target against a transaction-level expectation.
module tb_i2c_target_rx;

  localparam logic [6:0] DEV = 7'h50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  i2c_target_rx_if bus ();

  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  i2c_target_rx #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: logs delivered bytes and counts pulses and protocol violations.
  logic [8:0] rx_log [0:1023];
  int rx_n = 0, hit_cnt = 0, stop_cnt = 0, first_bad = 0, oe_bad = 0;
  logic prev_oe = 1'b0, prev_scl = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid && rx_n < 1024) begin
        rx_log[rx_n] = {bus.rx_first, bus.rx_data};
        rx_n++;
      end
      if (bus.addr_hit) hit_cnt++;
      if (bus.stop_det) stop_cnt++;
      if (!bus.rx_valid && bus.rx_first) first_bad++;
      if (prev_scl && m_scl && (bus.sda_oe != prev_oe)) oe_bad++;
    end
    prev_oe  = bus.sda_oe;
    prev_scl = m_scl;
  end

  logic [7:0] tx_data [0:7];

  task automatic send_bit(input logic b);
    repeat (4) @(negedge clk); m_sda = b;
    repeat (4) @(negedge clk); m_scl = 1'b1;
    repeat (8) @(negedge clk); m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    repeat (4) @(negedge clk); m_sda = 1'b1;
    repeat (4) @(negedge clk); m_scl = 1'b1;
    repeat (4) @(negedge clk); ack = bus.sda_i;
    repeat (4) @(negedge clk); m_scl = 1'b0;
  endtask

  task automatic send_start();
    repeat (4) @(negedge clk); m_sda = 1'b0;
    repeat (4) @(negedge clk); m_scl = 1'b0;
  endtask

  task automatic send_stop();
    repeat (4) @(negedge clk); m_sda = 1'b0;
    repeat (4) @(negedge clk); m_scl = 1'b1;
    repeat (4) @(negedge clk); m_sda = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_restart();
    repeat (4) @(negedge clk); m_sda = 1'b1;
    repeat (4) @(negedge clk); m_scl = 1'b1;
    repeat (4) @(negedge clk); m_sda = 1'b0;
    repeat (4) @(negedge clk); m_scl = 1'b0;
  endtask

  // One transaction; cut_bits>0 ends it with that many stray bits and a repeated START.
  task automatic run_txn(input logic [6:0] addr, input logic rw, input int nbytes,
                         input int cut_bits, input logic do_start);
    logic hit, ack;
    int b_hit, b_stop, b_rx;
    hit    = (addr == DEV) && (rw == 1'b0);
    b_hit  = hit_cnt;
    b_stop = stop_cnt;
    b_rx   = rx_n;
    if (do_start) send_start();
    send_byte({addr, rw}, ack);
    check_eq("addr_ack", ack, hit ? 1'b0 : 1'b1);
    check_eq("busy_after_addr", bus.busy, hit);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(tx_data[i], ack);
      check_eq("data_ack", ack, hit ? 1'b0 : 1'b1);
    end
    if (cut_bits > 0) begin
      for (int j = 0; j < cut_bits; j++) send_bit(1'($urandom_range(0, 1)));
      send_restart();
    end else begin
      send_stop();
    end
    check_eq("addr_hit_cnt", hit_cnt - b_hit, hit ? 1 : 0);
    check_eq("stop_det_cnt", stop_cnt - b_stop, (cut_bits > 0) ? 0 : 1);
    check_eq("busy_end", bus.busy, 1'b0);
    check_eq("rx_cnt", rx_n - b_rx, hit ? nbytes : 0);
    if (hit && (rx_n - b_rx) == nbytes) begin
      for (int i = 0; i < nbytes; i++)
        check_eq("rx_byte", rx_log[b_rx + i], {(i == 0), tx_data[i]});
    end
  endtask

  initial begin
    int k;
    logic       restarted;
    logic [6:0] a;
    logic       rw;
    int         n, cut;

    repeat (3) @(negedge clk);
    check_eq("rst_sda_oe", bus.sda_oe, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_rx_data", bus.rx_data, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("idle_pulses", {bus.rx_valid, bus.rx_first, bus.addr_hit, bus.stop_det}, 4'b0000);

    tx_data[0] = 8'hAA;
    run_txn(DEV, 1'b0, 1, 0, 1'b1);
    run_txn(7'h51, 1'b0, 1, 0, 1'b1);
    tx_data[0] = 8'h00;
    run_txn(DEV, 1'b1, 1, 0, 1'b1);
    tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33;
    run_txn(DEV, 1'b0, 3, 0, 1'b1);
    run_txn(DEV, 1'b0, 0, 4, 1'b1);
    tx_data[0] = 8'h5C;
    run_txn(DEV, 1'b0, 1, 0, 1'b0);

    // Reset while the target is holding the ACK low.
    send_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hA0) >> i) & 8'h01);
    k = 0;
    while (!bus.sda_oe && k < 32) begin
      @(negedge clk);
      k++;
    end
    check_eq("oe_before_rst", bus.sda_oe, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_oe", bus.sda_oe, 1'b0);
    check_eq("async_rst_busy", bus.busy, 1'b0);
    check_eq("async_rst_pulses", {bus.rx_valid, bus.rx_first, bus.addr_hit, bus.stop_det}, 4'b0000);
    m_sda = 1'b1;
    m_scl = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tx_data[0] = 8'($urandom_range(0, 255));
    run_txn(DEV, 1'b0, 1, 0, 1'b1);

    restarted = 1'b0;
    for (int it = 0; it < 12; it++) begin
      a   = ($urandom_range(0, 2) != 0) ? DEV : 7'($urandom_range(0, 127));
      rw  = ($urandom_range(0, 3) == 0);
      n   = $urandom_range(0, 3);
      cut = (it < 11 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom_range(0, 255));
      run_txn(a, rw, n, cut, !restarted);
      restarted = (cut > 0);
    end

    check_eq("rx_first_without_valid", first_bad, 0);
    check_eq("sda_oe_change_scl_high", oe_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
